gamepad_pmod_tx: RTL and testbench
==================================

// Module: gamepad_pmod_tx
// PURPOSE
//   Controller-side driver for the Gamepad Pmod serial link. Snapshots the button state of two
//   controllers, serialises it as one 24-bit frame on pmod_data/pmod_clk, then pulses pmod_latch.
//   Used in benches and loopback builds to stimulate the gamepad receiver on ui_in[6:4] without a
//   physical Pmod. It also lets one design drive another design's gamepad inputs.
// PARAMETERS
//   CLK_DIV    4     clk cycles per pmod_clk half-period (>=1); also the latch-high width
//   FRAME_GAP  1000  idle clk cycles between frame_done and the next LOAD (>=1)
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   synchronous active-low reset
//   enable      in   1   1 = send frames back-to-back, separated by FRAME_GAP
//   ctrl0_btn   in   12  controller 0 buttons, active-high
//   ctrl1_btn   in   12  controller 1 buttons, active-high
//   pmod_data   out  1   serial data, MSB first
//   pmod_clk    out  1   shift clock; receiver samples pmod_data on its rising edge
//   pmod_latch  out  1   high pulse after the last bit; receiver transfers its shift reg on it
//   busy        out  1   high from LOAD through LATCH_LO inclusive
//   frame_done  out  1   one-cycle pulse on the cycle after pmod_latch falls
// BEHAVIOUR
//   Button bit map (each ctrl): [11]B [10]Y [9]SELECT [8]START [7]UP [6]DOWN [5]LEFT [4]RIGHT
//     [3]A [2]X [1]L [0]R. Frame word = {ctrl0_btn, ctrl1_btn}; bit 23 is sent first.
//   Reset (rst_n=0 at posedge): state=IDLE, pmod_data=0, pmod_clk=0, pmod_latch=0, busy=0,
//     frame_done=0, gap counter=0. Reset mid-frame aborts immediately; no partial latch is issued.
//   All outputs are registered; no combinational path from any input to any output.
//   FSM: IDLE -> LOAD -> CLK_LO -> CLK_HI -> (CLK_LO | LATCH_HI) -> LATCH_LO -> IDLE.
//   IDLE: gap counter increments while enable=1 and clears while enable=0.
//     It leaves for LOAD when enable=1 and gap >= FRAME_GAP-1. After reset with enable held at 1,
//     LOAD is entered FRAME_GAP cycles later.
//   LOAD (1 cycle): shreg <= frame word, sampled this cycle. Inputs that change later are ignored
//     until the next LOAD. pmod_data <= word[23], bit_cnt <= 0, busy <= 1.
//   CLK_LO: pmod_clk=0 for CLK_DIV cycles; pmod_data is held stable.
//   CLK_HI: pmod_clk=1 for CLK_DIV cycles. At its end bit_cnt increments.
//     If bit_cnt was < 23: shreg shifts left by 1, pmod_data <= next bit (it changes together
//       with pmod_clk falling), and the FSM returns to CLK_LO.
//     If bit_cnt == 23: pmod_clk <= 0, pmod_data <= 0, and the FSM goes to LATCH_HI.
//   LATCH_HI: pmod_latch=1 for CLK_DIV cycles, pmod_clk=0.
//   LATCH_LO: 1 cycle with pmod_latch=0. Next cycle: IDLE, busy=0, frame_done=1 (one cycle), gap=0.
//   Exactly 24 pmod_clk rising edges and 1 latch pulse occur per frame.
//   Frame length = 1 + 48*CLK_DIV + CLK_DIV + 1 cycles, from LOAD to frame_done.
//   enable falling mid-frame: the current frame completes normally, then the FSM stays in IDLE.
//   enable rising while busy: no effect until IDLE is reached.
//   Counters: the divider counter is $clog2(CLK_DIV+1) bits and reloads on every phase change.
//     bit_cnt is 5 bits and saturates at 23. The gap counter is $clog2(FRAME_GAP+1) bits and
//     saturates at its top value; it never wraps.
// TESTING
//   1. Loopback into the gamepad receiver, ctrl0=12'h010 (RIGHT), ctrl1=0
//      -> after frame_done, receiver right=1 and all other ctrl0 buttons=0.
//   2. CLK_DIV=4, word 24'hA5_5A_C3 -> a rising-edge sampler captures 24'hA55AC3, exactly 24
//      rising edges, pmod_clk high 4 cycles / low 4 cycles, latch high 4 cycles, 198 cycles
//      from LOAD to frame_done.
//   3. ctrl0 changes from 12'h100 to 12'h000 on the 5th pmod_clk edge -> the frame carries START=1;
//      the next frame carries START=0.
//   4. enable dropped at bit 10 -> the frame completes with latch and frame_done, then no further
//      LOAD. enable held at 1 -> LOAD exactly FRAME_GAP cycles after each frame_done.
//   5. rst_n pulsed low for 1 cycle at bit 12 -> next cycle all outputs 0 and busy=0, no latch
//      pulse; after release, the first LOAD comes FRAME_GAP cycles later.
//   6. CLK_DIV=1, FRAME_GAP=1 -> pmod_clk toggles every cycle, frames repeat with a 1-cycle idle
//      gap, and data stays correct over 100 random frames.

Source files
------------

// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod transmitter: snapshots two 12-bit controller button words and shifts them out
// MSB first on pmod_data/pmod_clk, then pulses pmod_latch so the receiver transfers the frame.
module gamepad_pmod_tx #(
  parameter int CLK_DIV   = 4,
  parameter int FRAME_GAP = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] ctrl0_btn,
  input  logic [11:0] ctrl1_btn,
  output logic        pmod_data,
  output logic        pmod_clk,
  output logic        pmod_latch,
  output logic        busy,
  output logic        frame_done
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(FRAME_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(FRAME_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_MAX    = '1;
  localparam logic [4:0]       LAST_BIT   = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLK_LO, S_CLK_HI, S_LATCH_HI, S_LATCH_LO
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [23:0]      shreg_q, shreg_d;
  logic             data_q, data_d;
  logic             clk_q, clk_d;
  logic             latch_q, latch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    gap_d     = '0;
    shreg_d   = shreg_q;
    data_d    = data_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          gap_d = (gap_q != GAP_MAX) ? gap_q + GAP_W'(1) : gap_q;
          if (gap_q >= GAP_LAST) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d   = {ctrl0_btn, ctrl1_btn};
        data_d    = ctrl0_btn[11];
        bit_cnt_d = '0;
        div_d     = DIV_RELOAD;
        state_d   = S_CLK_LO;
      end
      S_CLK_LO: begin
        if (div_q == '0) begin
          div_d   = DIV_RELOAD;
          state_d = S_CLK_HI;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_CLK_HI: begin
        if (div_q == '0) begin
          div_d = DIV_RELOAD;
          // Data changes together with the falling shift clock so it is stable at the next rise.
          if (bit_cnt_q < LAST_BIT) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            shreg_d   = {shreg_q[22:0], 1'b0};
            data_d    = shreg_q[22];
            state_d   = S_CLK_LO;
          end else begin
            data_d  = 1'b0;
            state_d = S_LATCH_HI;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_LATCH_HI: begin
        if (div_q == '0) state_d = S_LATCH_LO;
        else             div_d   = div_q - DIV_W'(1);
      end
      S_LATCH_LO: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    clk_d   = (state_d == S_CLK_HI);
    latch_d = (state_d == S_LATCH_HI);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_LATCH_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
      shreg_q   <= '0;
      data_q    <= 1'b0;
      clk_q     <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      gap_q     <= gap_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      clk_q     <= clk_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pmod_data  = data_q;
  assign pmod_clk   = clk_q;
  assign pmod_latch = latch_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Bench for gamepad_pmod_tx: instance A (CLK_DIV=4, FRAME_GAP=20) for frame content/timing
// and enable/reset corners, instance B (CLK_DIV=1, FRAME_GAP=1) for back-to-back random frames.
module tb_gamepad_pmod_tx;
  localparam int A_DIV = 4;
  localparam int A_GAP = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_en, a_data, a_clk, a_latch, a_busy, a_done;
  logic [11:0] a_c0, a_c1;
  logic        b_rst_n, b_en, b_data, b_clk, b_latch, b_busy, b_done;
  logic [11:0] b_c0, b_c1;

  gamepad_pmod_tx #(.CLK_DIV(A_DIV), .FRAME_GAP(A_GAP)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .enable(a_en), .ctrl0_btn(a_c0), .ctrl1_btn(a_c1),
    .pmod_data(a_data), .pmod_clk(a_clk), .pmod_latch(a_latch), .busy(a_busy),
    .frame_done(a_done));

  gamepad_pmod_tx #(.CLK_DIV(1), .FRAME_GAP(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .enable(b_en), .ctrl0_btn(b_c0), .ctrl1_btn(b_c1),
    .pmod_data(b_data), .pmod_clk(b_clk), .pmod_latch(b_latch), .busy(b_busy),
    .frame_done(b_done));

  int vectors = 0;
  int miscompares = 0;

  // Monitor for instance A, sampled on the falling edge.
  int          cyc = 0;
  int          a_load_cyc = 0, a_done_cyc = 0, a_edges = 0, a_hi = 0, a_lat = 0;
  int          a_loads = 0, a_latches = 0, a_dones = 0;
  logic [23:0] a_cap = '0;
  logic        a_clk_p = 1'b0, a_busy_p = 1'b0, a_lat_p = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (a_busy && !a_busy_p) begin
      a_load_cyc = cyc; a_loads++; a_edges = 0; a_hi = 0; a_lat = 0; a_cap = '0;
    end
    if (a_clk && !a_clk_p) begin
      a_cap = {a_cap[22:0], a_data}; a_edges++;
    end
    if (a_clk) a_hi++;
    if (a_latch) a_lat++;
    if (a_latch && !a_lat_p) a_latches++;
    if (a_done) begin
      a_done_cyc = cyc; a_dones++;
    end
    a_clk_p = a_clk; a_busy_p = a_busy; a_lat_p = a_latch;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = a_dones;
    for (int i = 0; i < budget && a_dones == start; i++) tick();
    chk("frame_done wait", a_dones - start, 1);
  endtask

  task automatic wait_frame_edge(input int n, input int budget);
    int start;
    start = a_loads;
    for (int i = 0; i < budget && !(a_loads != start && a_edges >= n); i++) tick();
    chk("edge wait", (a_loads != start && a_edges >= n) ? 1 : 0, 1);
  endtask

  typedef struct packed {
    logic [11:0] c0;
    logic [11:0] c1;
    logic [23:0] word;
  } vec_t;
  vec_t vt[6];

  initial begin
    int prev, r, loads0, lat0, done0, frames, b_load, b_last_done, b_edges, b_hi;
    logic [23:0] b_cap, b_exp;
    logic b_clk_p, b_busy_p;

    vt[0] = '{c0: 12'hA55, c1: 12'h5A5 ^ 12'hF66, word: 24'hA55_AC3};
    vt[1] = '{c0: 12'h010, c1: 12'h000, word: 24'h010_000};
    vt[2] = '{c0: 12'hFFF, c1: 12'h000, word: 24'hFFF_000};
    vt[3] = '{c0: 12'h000, c1: 12'hFFF, word: 24'h000_FFF};
    vt[4] = '{c0: 12'h800, c1: 12'h001, word: 24'h800_001};
    vt[5] = '{c0: 12'h123, c1: 12'h456, word: 24'h123_456};

    a_rst_n = 1'b0; a_en = 1'b0; a_c0 = '0; a_c1 = '0;
    b_rst_n = 1'b0; b_en = 1'b1; b_c0 = '0; b_c1 = '0;
    repeat (3) tick();
    chk("reset data", a_data, 0);
    chk("reset clk", a_clk, 0);
    chk("reset latch", a_latch, 0);
    chk("reset busy", a_busy, 0);
    chk("reset done", a_done, 0);

    a_c0 = vt[0].c0; a_c1 = vt[0].c1; a_en = 1'b1; a_rst_n = 1'b1;
    prev = cyc;
    for (int i = 0; i < 6; i++) begin
      a_c0 = vt[i].c0; a_c1 = vt[i].c1;
      wait_done(A_GAP + 300);
      chk("word", a_cap, vt[i].word);
      chk("edges", a_edges, 24);
      chk("clk high cycles", a_hi, 24 * A_DIV);
      chk("latch cycles", a_lat, A_DIV);
      chk("frame length", a_done_cyc - a_load_cyc, 198);
      chk("gap to load", a_load_cyc - prev, A_GAP);
      prev = a_done_cyc;
    end

    // Inputs changing mid-frame are ignored until the next load.
    a_c0 = 12'h100; a_c1 = 12'h000;
    wait_frame_edge(5, A_GAP + 300);
    a_c0 = 12'h000;
    wait_done(300);
    chk("start held frame", a_cap, 24'h100_000);
    wait_done(A_GAP + 300);
    chk("start cleared frame", a_cap, 24'h000_000);

    // Enable dropped mid-frame: frame completes, then no further load.
    a_c0 = 12'h5A5; a_c1 = 12'h3C3;
    wait_frame_edge(10, A_GAP + 300);
    a_en = 1'b0;
    wait_done(300);
    chk("enable drop word", a_cap, 24'h5A5_3C3);
    chk("enable drop latch", a_lat, A_DIV);
    chk("busy after done", a_busy, 0);
    tick();
    chk("done one cycle", a_done, 0);
    loads0 = a_loads;
    repeat (3 * A_GAP) tick();
    chk("no load when disabled", a_loads - loads0, 0);

    // Reset mid-frame aborts without a latch, then restarts after FRAME_GAP.
    a_en = 1'b1; a_c0 = 12'hFFF; a_c1 = 12'hFFF;
    wait_frame_edge(12, A_GAP + 300);
    lat0 = a_latches; done0 = a_dones;
    a_rst_n = 1'b0;
    tick();
    chk("abort data", a_data, 0);
    chk("abort clk", a_clk, 0);
    chk("abort latch", a_latch, 0);
    chk("abort busy", a_busy, 0);
    chk("abort done", a_done, 0);
    a_rst_n = 1'b1; r = cyc;
    a_c0 = 12'h00F; a_c1 = 12'hF00;
    loads0 = a_loads;
    for (int i = 0; i < A_GAP + 10 && a_loads == loads0; i++) tick();
    chk("load after reset", a_load_cyc - r, A_GAP);
    chk("no latch on abort", a_latches - lat0, 0);
    chk("no done on abort", a_dones - done0, 0);
    wait_done(300);
    chk("word after reset", a_cap, 24'h00F_F00);

    // Instance B: fastest divider, 1-cycle gaps, random content.
    b_c0 = 12'($urandom); b_c1 = 12'($urandom);
    b_rst_n = 1'b1;
    frames = 0; b_load = 0; b_last_done = 0; b_edges = 0; b_hi = 0;
    b_cap = '0; b_exp = '0; b_clk_p = 1'b0; b_busy_p = 1'b0;
    for (int c = 0; c < 8000 && frames < 100; c++) begin
      tick();
      if (b_busy && !b_busy_p) begin
        if (frames > 0) chk("b gap", c - b_last_done, 1);
        b_load = c; b_exp = {b_c0, b_c1}; b_edges = 0; b_hi = 0; b_cap = '0;
      end
      if (b_clk && !b_clk_p) begin
        b_cap = {b_cap[22:0], b_data}; b_edges++;
      end
      if (b_clk) b_hi++;
      if (b_done) begin
        chk("b word", b_cap, b_exp);
        chk("b edges", b_edges, 24);
        chk("b clk high cycles", b_hi, 24);
        chk("b frame length", c - b_load, 51);
        frames++; b_last_done = c;
        b_c0 = 12'($urandom); b_c1 = 12'($urandom);
      end
      b_clk_p = b_clk; b_busy_p = b_busy;
    end
    chk("b frames", frames, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
